// File: rtl/alu_addsub_pipe_pkg.sv
// Shared ALU control definitions: op encodings and decode helpers for the add/sub datapath.
// op[1] selects subtract, op[0] selects unsigned (overflow suppressed).
package alu_addsub_pipe_pkg;

  localparam int ALU_OP_W = 2;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 2'b00,
    ALU_ADDU = 2'b01,
    ALU_SUB  = 2'b10,
    ALU_SUBU = 2'b11
  } alu_op_e;

  function automatic logic op_is_sub(input logic [ALU_OP_W-1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [ALU_OP_W-1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/alu_addsub_slice.sv
// Slice-width ripple adder used by one pipeline stage.
// Latency: combinational. Backpressure: none, pure datapath.
module alu_addsub_slice
  import alu_addsub_pipe_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         cmsb
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

  // Carry into the MSB recovered from the MSB sum bit; feeds signed overflow.
  assign cmsb = a[W-1] ^ b[W-1] ^ sum[W-1];

endmodule

// File: rtl/alu_addsub_pipe.sv
// Pipelined add/sub: one WIDTH/STAGES slice per stage, carry rippled through stage registers.
// Latency: STAGES cycles from acceptance to out_valid. Backpressure: whole pipe stalls when
// out_valid && !out_ready; in_ready mirrors the advance enable.
module alu_addsub_pipe
  import alu_addsub_pipe_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             carry,
  output logic             ovf,
  output logic             zero,
  output logic [TAG_W-1:0] out_tag
);

  localparam int SW = WIDTH / STAGES;

  logic en;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  genvar k;
  for (k = 0; k < STAGES; k++) begin : g_st
    logic [WIDTH-1:0] a_i, b_i, sum_i, sum_n;
    logic             c_i, vld_i, sgn_i;
    logic [TAG_W-1:0] tag_i;
    logic [SW-1:0]    s_sum;
    logic             s_cout, s_cmsb;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic             c_q, m_q, vld_q, sgn_q;
    logic [TAG_W-1:0] tag_q;
    logic             unused_q;

    // Stage 0 folds the subtract into operand inversion plus carry-in.
    if (k == 0) begin : g_src
      assign a_i   = a;
      assign b_i   = op_is_sub(op) ? ~b : b;
      assign c_i   = op_is_sub(op);
      assign vld_i = in_valid;
      assign sgn_i = op_is_signed(op);
      assign tag_i = in_tag;
      assign sum_i = '0;
    end else begin : g_src
      assign a_i   = g_st[k-1].a_q;
      assign b_i   = g_st[k-1].b_q;
      assign c_i   = g_st[k-1].c_q;
      assign vld_i = g_st[k-1].vld_q;
      assign sgn_i = g_st[k-1].sgn_q;
      assign tag_i = g_st[k-1].tag_q;
      assign sum_i = g_st[k-1].sum_q;
    end

    alu_addsub_slice #(.W(SW)) u_slice (
      .a    (a_i[k*SW +: SW]),
      .b    (b_i[k*SW +: SW]),
      .cin  (c_i),
      .sum  (s_sum),
      .cout (s_cout),
      .cmsb (s_cmsb)
    );

    always_comb begin
      sum_n               = sum_i;
      sum_n[k*SW +: SW]   = s_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        a_q   <= '0;
        b_q   <= '0;
        sum_q <= '0;
        c_q   <= 1'b0;
        m_q   <= 1'b0;
        vld_q <= 1'b0;
        sgn_q <= 1'b0;
        tag_q <= '0;
      end else if (en) begin
        a_q   <= a_i;
        b_q   <= b_i;
        sum_q <= sum_n;
        c_q   <= s_cout;
        m_q   <= s_cmsb;
        vld_q <= vld_i;
        sgn_q <= sgn_i;
        tag_q <= tag_i;
      end
    end

    // Operand copies past the last stage and intermediate MSB carries have no consumer.
    assign unused_q = ^{a_q, b_q, m_q};
  end

  assign out_valid = g_st[STAGES-1].vld_q;
  assign y         = g_st[STAGES-1].sum_q;
  assign carry     = g_st[STAGES-1].c_q;
  assign ovf       = g_st[STAGES-1].sgn_q & (g_st[STAGES-1].m_q ^ g_st[STAGES-1].c_q);
  assign zero      = ~|y;
  assign out_tag   = g_st[STAGES-1].tag_q;

endmodule

// File: doc/alu_addsub_pipe.md
ALU_ADDSUB_PIPE -- requirements
Module: alu_addsub_pipe

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; legal 8..64.
REQ-002 Parameter STAGES, default 4, pipeline depth; legal 1..8; WIDTH SHALL be a multiple of STAGES.
REQ-003 Parameter TAG_W, default 4, width of the sideband tag carried with each operation.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  operation presented on a, b, op, in_tag.
REQ-007 in_ready  output  1  block accepts the operation this cycle.
REQ-008 a, b  input  WIDTH  operands.
REQ-009 op  input  2  00 ADD, 01 ADDU, 10 SUB, 11 SUBU.
REQ-010 in_tag  input  TAG_W  sideband returned unchanged with the result.
REQ-011 out_valid  output  1  result on y and flags is valid.
REQ-012 out_ready  input  1  consumer takes the result this cycle.
REQ-013 y  output  WIDTH  a+b or a-b, modulo 2^WIDTH.
REQ-014 carry  output  1  carry out of MSB; for SUB/SUBU, 1 = no borrow.
REQ-015 ovf  output  1  signed overflow; only for ADD/SUB, 0 for ADDU/SUBU.
REQ-016 zero  output  1  y == 0.
REQ-017 out_tag  output  TAG_W  in_tag of the operation producing this result.

Function
REQ-018 Subtraction SHALL be computed as a + ~b + 1 (carry-in 1); addition with carry-in 0.
REQ-019 Operand is split into STAGES slices of WIDTH/STAGES bits; stage k SHALL add slice k using the registered carry from stage k-1, LSB slice first.
REQ-020 Unconsumed upper operand slices and completed lower result slices SHALL be carried forward in stage registers so one operation occupies exactly one stage.
REQ-021 ovf = carry into MSB XOR carry out of MSB, gated by op[0]==0.
REQ-022 Handshake transfer on input when in_valid && in_ready; on output when out_valid && out_ready.
REQ-023 Pipeline advance enable en = !out_valid || out_ready; in_ready SHALL equal en (combinational, no dependency on in_valid).
REQ-024 When en=0 every stage register, valid bit and tag SHALL hold; no operation lost or duplicated.
REQ-025 Latency: a transfer accepted at cycle t with en held high SHALL yield out_valid at cycle t+STAGES.
REQ-026 Throughput: one operation per cycle while out_ready=1 continuously.
REQ-027 Bubbles (in_valid=0 when en=1) SHALL propagate as invalid stages; y/flags under out_valid=0 are don't-care but SHALL not be X after reset.
REQ-028 Simultaneous output transfer and input acceptance in one cycle SHALL be supported with a full pipeline.
REQ-029 Results SHALL emerge in acceptance order with matching out_tag.
REQ-030 STAGES=1 SHALL reduce to one registered full-width add with identical flag rules.

Reset
REQ-031 While rst_n=0: all stage valid bits, out_valid, y, carry, ovf, out_tag SHALL be 0; zero SHALL be 1 (reflecting y=0).
REQ-032 Reset asserted mid-operation SHALL discard all in-flight operations; none SHALL appear after release.
REQ-033 First acceptance possible in the first rising edge after rst_n deasserts (in_ready=1 since out_valid=0).

Structure
REQ-034 Op encodings (ADD, ADDU, SUB, SUBU) SHALL live in the shared ALU package alongside existing ALU control constants.
REQ-035 One sub-module alu_addsub_slice (slice-width adder: inputs slice a, slice b, cin; outputs sum, cout, carry-into-MSB) SHALL be instantiated once per stage via generate.
REQ-036 No multipliers, no latches, no clock gating; all registers reset asynchronously.

Verification
REQ-037 WIDTH=32, STAGES=4: ADD 0x7FFFFFFF+0x00000001 -> y=0x80000000, ovf=1, carry=0, zero=0, out_valid exactly 4 cycles after acceptance.
REQ-038 SUBU 0x00000005-0x00000005 -> y=0, zero=1, carry=1, ovf=0; SUB 0x00000000-0x00000001 -> y=0xFFFFFFFF, carry=0, ovf=0.
REQ-039 ADDU 0xFFFFFFFF+0x00000001 -> y=0, carry=1, ovf=0 (ovf suppressed), zero=1.
REQ-040 Stream 16 back-to-back ops with tags 0..15, out_ready=1 -> 16 results on consecutive cycles, tags in order, values match reference model.
REQ-041 Fill pipeline, hold out_ready=0 for 5 cycles -> in_ready=0, outputs stable; release -> all results delivered in order, none lost.
REQ-042 Assert rst_n=0 with 3 ops in flight -> out_valid=0 immediately; after release no stale result appears; repeat REQ-037 with STAGES=1 and WIDTH=64, STAGES=8.
